fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 27 ++
 rtl/fetch_unit_if.sv | 13 +
 rtl/fetch_unit_return_stack.sv | 56 +++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch unit: next-PC select codes, call/return opcodes, FSM encoding.
package fetch_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        PC_NEXT = 2'b00,
        PC_JA   = 2'b01,
        PC_BTA  = 2'b10,
        PC_TOS  = 2'b11
    } pc_ctrl_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_FETCH  = 2'b01,
        S_ISSUE  = 2'b10,
        S_UPDATE = 2'b11
    } fetch_state_e;

    localparam logic [5:0] OP_CALL = 6'b000011;
    localparam logic [5:0] OP_RET  = 6'b000100;

    function automatic logic [XLEN-1:0] sext16(input logic [15:0] v);
        return {{(XLEN - 16){v[15]}}, v};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port: request/address out of the fetch unit, ready/data back.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic [XLEN-1:0] data;

    modport master (output req, output addr, input ready, input data);
    modport slave  (input req, input addr, output ready, output data);

endinterface

// File: rtl/fetch_unit_return_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module return_stack
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic            full,
    output logic            empty,
    output logic [XLEN-1:0] top
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CAP  = CW'(DEPTH);

    logic [XLEN-1:0] slots [DEPTH];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   wp_inc;
    logic [PW-1:0]   wp_dec;
    logic [CW-1:0]   count;

    // wp is the next free slot; the newest entry sits just below it
    assign wp_inc = (wp == LAST) ? '0 : wp + PW'(1);
    assign wp_dec = (wp == '0) ? LAST : wp - PW'(1);
    assign full   = (count == CAP);
    assign empty  = (count == '0);
    assign top    = slots[wp_dec];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp    <= '0;
            count <= '0;
        end else if (push) begin
            wp <= wp_inc;
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (pop && !empty) begin
            wp    <= wp_dec;
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            slots[wp] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: IDLE -> FETCH (holds im_req until im_ready) -> ISSUE (until ex_done) -> UPDATE (loads PC).
// instr_valid rises one cycle after im_ready; optional return stack enabled by FETCH_RAS_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          RAS_DEPTH = 4
) (
    input  logic            clock,
    input  logic            reset,
    fetch_unit_if.master    im,
    output logic [XLEN-1:0] instr,
    output logic [5:0]      opcode,
    output logic            instr_valid,
    input  logic [1:0]      pc_control,
    input  logic            br_taken,
    input  logic            ex_done,
    input  logic [XLEN-1:0] tos_addr,
    output logic [XLEN-1:0] ret_addr,
    output logic [XLEN-1:0] pc
);

    if (RAS_DEPTH < 2) begin : g_bad_ras_depth
        $error("fetch_unit: RAS_DEPTH must be at least 2");
    end

    fetch_state_e    state;
    fetch_state_e    state_nxt;
    logic            fetch_req;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] stack_ret;

    assign opcode   = instr[31:26];
    assign ret_addr = pc + 32'd1;
    assign im.req   = fetch_req;
    assign im.addr  = pc;

`ifdef FETCH_RAS_EN
    logic            ras_push;
    logic            ras_pop;
    logic            ras_full;
    logic            ras_empty;
    logic [XLEN-1:0] ras_top;

    assign ras_push = (state == S_UPDATE) && (opcode == OP_CALL);
    assign ras_pop  = (state == S_UPDATE) && (opcode == OP_RET);

    return_stack #(
        .DEPTH (RAS_DEPTH)
    ) u_return_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (ret_addr),
        .full      (ras_full),
        .empty     (ras_empty),
        .top       (ras_top)
    );

    // A RET on an empty stack falls back to the data-memory stack top
    assign stack_ret = (opcode == OP_RET && !ras_empty) ? ras_top : tos_addr;
`else
    assign stack_ret = tos_addr;
`endif

    always_comb begin
        pc_nxt = ret_addr;
        case (pc_ctrl_e'(pc_control))
            PC_NEXT: pc_nxt = ret_addr;
            PC_JA:   pc_nxt = {pc[31:26], instr[25:0]};
            PC_BTA:  pc_nxt = br_taken ? (ret_addr + sext16(instr[15:0])) : ret_addr;
            PC_TOS:  pc_nxt = stack_ret;
            default: pc_nxt = ret_addr;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_FETCH && im.ready) begin
                instr <= im.data;
            end
            if (state == S_UPDATE) begin
                pc <= pc_nxt;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        fetch_req   = 1'b0;
        instr_valid = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                fetch_req = 1'b1;
                if (im.ready) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                if (ex_done) begin
                    state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: begin
                state_nxt = S_FETCH;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit against a queue-based next-PC reference model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0;
    localparam int          DEPTH  = 4;

    logic        clock;
    logic        reset;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic [1:0]  pc_control;
    logic        br_taken;
    logic        ex_done;
    logic [31:0] tos_addr;
    logic [31:0] ret_addr;
    logic [31:0] pc;

    fetch_unit_if imem ();

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .im          (imem),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc_control  (pc_control),
        .br_taken    (br_taken),
        .ex_done     (ex_done),
        .tos_addr    (tos_addr),
        .ret_addr    (ret_addr),
        .pc          (pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] pc_m;
`ifdef FETCH_RAS_EN
    logic [31:0] ras_m[$];
`endif

    typedef struct packed {
        logic        timeout;
        logic        req_held;
        logic        early_valid;
        logic        valid_at_rdy;
        logic        valid_next;
        logic        hold_bad;
        logic        valid_upd;
        logic [31:0] exp_addr;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] ret;
        logic [31:0] pc;
        logic [5:0]  opcode;
    } obs_t;

    task automatic model_reset();
        pc_m = RST_PC;
`ifdef FETCH_RAS_EN
        ras_m.delete();
`endif
    endtask

    // Architectural next-PC rule, with the return stack as a bounded LIFO
    task automatic model_update(input logic [31:0] ins, input logic [1:0] pcc,
                                input logic bt, input logic [31:0] tos);
        logic [31:0] seq;
        logic [31:0] ret_val;
        logic [31:0] off;
        seq     = pc_m + 32'd1;
        ret_val = tos;
        off     = {{16{ins[15]}}, ins[15:0]};
`ifdef FETCH_RAS_EN
        if (ins[31:26] == OP_RET && ras_m.size() > 0) ret_val = ras_m.pop_back();
        if (ins[31:26] == OP_CALL) begin
            ras_m.push_back(seq);
            if (ras_m.size() > DEPTH) void'(ras_m.pop_front());
        end
`endif
        case (pcc)
            2'b00:   pc_m = seq;
            2'b01:   pc_m = {pc_m[31:26], ins[25:0]};
            2'b10:   pc_m = bt ? seq + off : seq;
            default: pc_m = ret_val;
        endcase
    endtask

    // Drives one fetch/issue/update round trip and records what the DUT showed
    task automatic run_instr(input logic [31:0] data, input int rdy_dly, input logic [1:0] pcc,
                             input logic bt, input int ex_dly, input logic [31:0] tos,
                             output obs_t o);
        int n;
        o = '0;
        o.req_held = 1'b1;
        o.exp_addr = pc_m;
        n = 0;
        while (imem.req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        o.timeout = (imem.req !== 1'b1);
        o.addr = imem.addr;
        for (int i = 0; i < rdy_dly; i++) begin
            imem.ready = 1'b0;
            imem.data  = $urandom;
            ex_done    = 1'($urandom);
            @(negedge clock);
            if (imem.req !== 1'b1) o.req_held = 1'b0;
            if (instr_valid !== 1'b0) o.early_valid = 1'b1;
        end
        imem.ready = 1'b1;
        imem.data  = data;
        ex_done    = 1'($urandom);
        o.valid_at_rdy = instr_valid;
        @(negedge clock);
        o.valid_next = instr_valid;
        o.instr      = instr;
        o.opcode     = opcode;
        imem.ready   = 1'($urandom);
        imem.data    = $urandom;
        ex_done      = 1'b0;
        for (int i = 0; i < ex_dly; i++) begin
            pc_control = 2'($urandom);
            br_taken   = 1'($urandom);
            tos_addr   = $urandom;
            @(negedge clock);
            if (instr_valid !== 1'b1 || instr !== data) o.hold_bad = 1'b1;
        end
        ex_done = 1'b1;
        @(negedge clock);
        o.valid_upd = instr_valid;
        o.ret       = ret_addr;
        ex_done     = 1'($urandom);
        pc_control  = pcc;
        br_taken    = bt;
        tos_addr    = tos;
        @(negedge clock);
        o.pc       = pc;
        imem.ready = 1'b0;
        ex_done    = 1'b0;
        model_update(data, pcc, bt, tos);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        n_vec++; if (pc !== RST_PC) begin n_err++; $display("FAIL reset_pc: got %h expected %h", pc, RST_PC); end
        n_vec++; if (imem.req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", imem.req); end
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", instr_valid); end
        n_vec++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h expected 0", instr); end
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        @(negedge clock);
        n_vec++; if (imem.req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b expected 0", imem.req); end
        @(negedge clock);
        n_vec++; if (imem.req !== 1'b1) begin n_err++; $display("FAIL fetch_req: got %b expected 1", imem.req); end
    endtask

    task automatic test_first_fetch();
        obs_t o;
        run_instr(32'h0400_0005, 3, 2'b00, 1'b0, 1, 32'h0, o);
        n_vec++; if (o.timeout !== 1'b0) begin n_err++; $display("FAIL first_timeout: got %b expected 0", o.timeout); end
        n_vec++; if (o.addr !== 32'h0) begin n_err++; $display("FAIL first_addr: got %h expected 0", o.addr); end
        n_vec++; if (o.req_held !== 1'b1) begin n_err++; $display("FAIL first_req_held: got %b expected 1", o.req_held); end
        n_vec++; if (o.opcode !== 6'b000001) begin n_err++; $display("FAIL first_opcode: got %b expected 000001", o.opcode); end
        n_vec++; if (o.valid_at_rdy !== 1'b0) begin n_err++; $display("FAIL first_valid_early: got %b expected 0", o.valid_at_rdy); end
        n_vec++; if (o.valid_next !== 1'b1) begin n_err++; $display("FAIL first_valid_latency: got %b expected 1", o.valid_next); end
        n_vec++; if (o.valid_upd !== 1'b0) begin n_err++; $display("FAIL first_valid_update: got %b expected 0", o.valid_upd); end
        n_vec++; if (o.pc !== 32'd1) begin n_err++; $display("FAIL first_pc: got %h expected 1", o.pc); end
    endtask

    task automatic test_branch();
        obs_t o;
        run_instr({6'd0, 26'd10}, 0, 2'b01, 1'b0, 0, 32'h0, o);
        n_vec++; if (o.pc !== 32'd10) begin n_err++; $display("FAIL ja_to_10: got %h expected %h", o.pc, 32'd10); end
        run_instr(32'h0000_FFFC, 1, 2'b10, 1'b1, 2, 32'h0, o);
        n_vec++; if (o.pc !== 32'd7) begin n_err++; $display("FAIL bta_taken: got %h expected %h", o.pc, 32'd7); end
        run_instr({6'd0, 26'd10}, 2, 2'b01, 1'b1, 0, 32'h0, o);
        run_instr(32'h0000_FFFC, 0, 2'b10, 1'b0, 1, 32'h0, o);
        n_vec++; if (o.pc !== 32'd11) begin n_err++; $display("FAIL bta_not_taken: got %h expected %h", o.pc, 32'd11); end
    endtask

    task automatic test_wrap();
        obs_t o;
        run_instr(32'h0000_0000, 0, 2'b11, 1'b0, 0, 32'hFFFF_FFFF, o);
        n_vec++; if (o.pc !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL tos_load: got %h expected ffffffff", o.pc); end
        run_instr({6'd0, 26'h3FF_FFFF}, 1, 2'b01, 1'b0, 0, 32'h0, o);
        n_vec++; if (o.pc !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ja_keeps_upper: got %h expected ffffffff", o.pc); end
        run_instr(32'h0000_0000, 0, 2'b00, 1'b0, 1, 32'h0, o);
        n_vec++; if (o.ret !== 32'h0) begin n_err++; $display("FAIL ret_addr_wrap: got %h expected 0", o.ret); end
        n_vec++; if (o.pc !== 32'h0) begin n_err++; $display("FAIL pc_wrap: got %h expected 0", o.pc); end
    endtask

    task automatic test_ras();
        obs_t o;
        run_instr({6'd0, 26'd20}, 0, 2'b01, 1'b0, 0, 32'h0, o);
`ifdef FETCH_RAS_EN
        run_instr({OP_CALL, 26'd50}, 0, 2'b01, 1'b0, 0, 32'h0, o);
        n_vec++; if (o.pc !== 32'd50) begin n_err++; $display("FAIL call_target: got %h expected %h", o.pc, 32'd50); end
        run_instr({OP_RET, 26'd0}, 1, 2'b11, 1'b0, 1, 32'd99, o);
        n_vec++; if (o.pc !== 32'd21) begin n_err++; $display("FAIL ret_from_stack: got %h expected %h", o.pc, 32'd21); end
        run_instr({OP_RET, 26'd0}, 0, 2'b11, 1'b0, 0, 32'd99, o);
        n_vec++; if (o.pc !== 32'd99) begin n_err++; $display("FAIL ret_empty: got %h expected %h", o.pc, 32'd99); end
        for (int i = 0; i <= DEPTH; i++) run_instr({OP_CALL, 26'd0}, 0, 2'b00, 1'b0, 0, 32'h0, o);
        for (int i = 0; i <= DEPTH; i++) begin
            run_instr({OP_RET, 26'd0}, 0, 2'b11, 1'b0, 0, 32'd7, o);
            n_vec++;
            if (o.pc !== ((i < DEPTH) ? 32'(100 + DEPTH - i) : 32'd7)) begin
                n_err++;
                $display("FAIL ras_overflow_pop%0d: got %h expected %h", i, o.pc,
                         (i < DEPTH) ? 32'(100 + DEPTH - i) : 32'd7);
            end
        end
`else
        run_instr({OP_CALL, 26'd50}, 0, 2'b01, 1'b0, 0, 32'h0, o);
        run_instr({OP_RET, 26'd0}, 1, 2'b11, 1'b0, 1, 32'd99, o);
        n_vec++; if (o.pc !== 32'd99) begin n_err++; $display("FAIL ret_no_ras: got %h expected %h", o.pc, 32'd99); end
`endif
    endtask

    task automatic test_random();
        obs_t        o;
        logic [31:0] data;
        logic [31:0] tos;
        logic [1:0]  pcc;
        logic        bt;
        int          pick;
        for (int k = 0; k < 60; k++) begin
            data = $urandom;
            pick = $urandom_range(0, 3);
            if (pick == 0) data[31:26] = OP_CALL;
            if (pick == 1) data[31:26] = OP_RET;
            pcc = 2'($urandom);
            bt  = 1'($urandom);
            tos = $urandom;
            run_instr(data, $urandom_range(0, 4), pcc, bt, $urandom_range(0, 3), tos, o);
            n_vec++; if (o.addr !== o.exp_addr) begin n_err++; $display("FAIL rnd%0d_addr: got %h expected %h", k, o.addr, o.exp_addr); end
            n_vec++; if (o.instr !== data) begin n_err++; $display("FAIL rnd%0d_instr: got %h expected %h", k, o.instr, data); end
            n_vec++; if (o.ret !== o.exp_addr + 32'd1) begin n_err++; $display("FAIL rnd%0d_ret_addr: got %h expected %h", k, o.ret, o.exp_addr + 32'd1); end
            n_vec++; if (o.pc !== pc_m) begin n_err++; $display("FAIL rnd%0d_pc: got %h expected %h (pcc %b bt %b)", k, o.pc, pc_m, pcc, bt); end
            n_vec++;
            if ({o.timeout, o.req_held, o.early_valid, o.valid_at_rdy, o.valid_next, o.hold_bad, o.valid_upd} !== 7'b0100100) begin
                n_err++;
                $display("FAIL rnd%0d_handshake: got %b expected 0100100", k,
                         {o.timeout, o.req_held, o.early_valid, o.valid_at_rdy, o.valid_next, o.hold_bad, o.valid_upd});
            end
        end
    endtask

    task automatic test_reset_midfetch();
        obs_t o;
        run_instr({6'd0, 26'h123}, 0, 2'b01, 1'b0, 0, 32'h0, o);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        n_vec++; if (imem.req !== 1'b0) begin n_err++; $display("FAIL midfetch_req: got %b expected 0", imem.req); end
        n_vec++; if (pc !== RST_PC) begin n_err++; $display("FAIL midfetch_pc: got %h expected %h", pc, RST_PC); end
        @(posedge clock);
        #1 reset = 1'b0;
        model_reset();
        run_instr(32'h0800_0000, 1, 2'b00, 1'b0, 0, 32'h0, o);
        n_vec++; if (o.addr !== RST_PC) begin n_err++; $display("FAIL restart_addr: got %h expected %h", o.addr, RST_PC); end
        n_vec++; if (o.pc !== RST_PC + 32'd1) begin n_err++; $display("FAIL restart_pc: got %h expected %h", o.pc, RST_PC + 32'd1); end
    endtask

    initial begin
        reset      = 1'b1;
        imem.ready = 1'b0;
        imem.data  = 32'h0;
        pc_control = 2'b00;
        br_taken   = 1'b0;
        ex_done    = 1'b0;
        tos_addr   = 32'h0;
        pc_m       = RST_PC;
        test_reset();
        test_first_fetch();
        test_branch();
        test_wrap();
        test_ras();
        test_random();
        test_reset_midfetch();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
